// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA request arbiter.
// DMA_ARB_TIMEOUT_EN (optional) enables the stuck-transaction timeout in the top level.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2,
        DRAIN   = 2'd3
    } arb_state_e;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int unsigned ARB_TIMEOUT_CYCLES = 65535;
    localparam int unsigned TO_CNT_W           = 16;

    function automatic logic [1:0] req_onehot(input logic id);
        return (id == REQ_DCACHE) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick (combinational) with a registered priority pointer.
// The pointer moves to the requester that did not own the last completed transaction.
module rr_arbiter2
    import dma_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       last_id_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic rr_q;

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = req_i[rr_q] ? rr_q : ~rr_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_q <= REQ_ICACHE;
        end else if (advance_i) begin
            rr_q <= ~last_id_i;
        end
    end

endmodule

// File: rtl/dma_request_arbiter.sv
// Serialises I-cache / D-cache refill and write-back requests onto the single DMA engine.
// Optional macro DMA_ARB_TIMEOUT_EN adds a 65535-cycle abort with arb_timeout/arb_timeout_sticky.
//
// state   | meaning
// IDLE    | no transaction; pick a requester by round-robin, write-back first
// RD_BUSY | page-fault refill in flight; wait for dma_page_fault_done
// WR_BUSY | write-back in flight; wait for dma_write_back_done
// DRAIN   | completed; wait for both level dones to drop before re-arbitrating
module dma_request_arbiter
    import dma_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8
) (
    input  logic                         cpu_clk,
    input  logic                         cpu_rst_n,
    input  logic [1:0]                   req_rd,
    input  logic [2*ADDR_WIDTH-1:0]      req_rd_addr,
    input  logic [2*READ_BURST_LEN-1:0]  req_rd_len,
    output logic [1:0]                   req_rd_done,
    input  logic [1:0]                   req_wr,
    input  logic [2*ADDR_WIDTH-1:0]      req_wr_addr,
    input  logic [2*WRITE_BURST_LEN-1:0] req_wr_len,
    output logic [1:0]                   req_wr_done,
    output logic                         dma_page_fault_happen,
    input  logic                         dma_page_fault_done,
    output logic [ADDR_WIDTH-1:0]        dma_page_fault_addr,
    output logic [READ_BURST_LEN-1:0]    dma_page_fault_burst_len,
    output logic                         dma_write_back_happen,
    input  logic                         dma_write_back_done,
    output logic [ADDR_WIDTH-1:0]        dma_write_back_addr,
    output logic [WRITE_BURST_LEN-1:0]   dma_write_back_burst_len,
    output logic                         grant_id,
    output logic                         busy
`ifdef DMA_ARB_TIMEOUT_EN
    ,
    output logic                         arb_timeout,
    output logic                         arb_timeout_sticky
`endif
);

    arb_state_e                 state_q;
    logic                       grant_q;
    logic                       busy_q;
    logic                       pf_happen_q;
    logic                       wb_happen_q;
    logic [ADDR_WIDTH-1:0]      pf_addr_q;
    logic [READ_BURST_LEN-1:0]  pf_len_q;
    logic [ADDR_WIDTH-1:0]      wb_addr_q;
    logic [WRITE_BURST_LEN-1:0] wb_len_q;
    logic [1:0]                 rd_done_q;
    logic [1:0]                 wr_done_q;

    logic                       gnt_valid;
    logic                       gnt_id;
    logic                       win_wr;
    logic [ADDR_WIDTH-1:0]      sel_rd_addr_d;
    logic [READ_BURST_LEN-1:0]  sel_rd_len_d;
    logic [ADDR_WIDTH-1:0]      sel_wr_addr_d;
    logic [WRITE_BURST_LEN-1:0] sel_wr_len_d;
    logic                       to_expired;
    logic                       rd_fin;
    logic                       wr_fin;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LOAD = TO_CNT_W'(ARB_TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] to_cnt_q;
    logic                timeout_q;
    logic                sticky_q;

    // Reloaded every idle cycle so it holds the full budget on the grant edge.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            to_cnt_q <= TO_LOAD;
        end else if (state_q == IDLE) begin
            to_cnt_q <= TO_LOAD;
        end else if ((state_q == RD_BUSY || state_q == WR_BUSY) && to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - 1'b1;
        end
    end

    assign to_expired         = (to_cnt_q == '0);
    assign arb_timeout        = timeout_q;
    assign arb_timeout_sticky = sticky_q;
`else
    assign to_expired = 1'b0;
`endif

    rr_arbiter2 u_rr (
        .clk_i       (cpu_clk),
        .rst_n_i     (cpu_rst_n),
        .req_i       (req_rd | req_wr),
        .advance_i   (rd_fin | wr_fin),
        .last_id_i   (grant_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        if (gnt_id == REQ_DCACHE) begin
            win_wr        = req_wr[1];
            sel_rd_addr_d = req_rd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            sel_rd_len_d  = req_rd_len[2*READ_BURST_LEN-1:READ_BURST_LEN];
            sel_wr_addr_d = req_wr_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            sel_wr_len_d  = req_wr_len[2*WRITE_BURST_LEN-1:WRITE_BURST_LEN];
        end else begin
            win_wr        = req_wr[0];
            sel_rd_addr_d = req_rd_addr[ADDR_WIDTH-1:0];
            sel_rd_len_d  = req_rd_len[READ_BURST_LEN-1:0];
            sel_wr_addr_d = req_wr_addr[ADDR_WIDTH-1:0];
            sel_wr_len_d  = req_wr_len[WRITE_BURST_LEN-1:0];
        end
    end

    assign rd_fin = (state_q == RD_BUSY) && (dma_page_fault_done || to_expired);
    assign wr_fin = (state_q == WR_BUSY) && (dma_write_back_done || to_expired);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= REQ_ICACHE;
            busy_q      <= 1'b0;
            pf_happen_q <= 1'b0;
            wb_happen_q <= 1'b0;
            pf_addr_q   <= '0;
            pf_len_q    <= '0;
            wb_addr_q   <= '0;
            wb_len_q    <= '0;
            rd_done_q   <= '0;
            wr_done_q   <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
            timeout_q   <= 1'b0;
            sticky_q    <= 1'b0;
`endif
        end else begin
            rd_done_q <= '0;
            wr_done_q <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        grant_q <= gnt_id;
                        busy_q  <= 1'b1;
                        // Write-back wins so a dirty eviction lands before its refill.
                        if (win_wr) begin
                            wb_addr_q   <= sel_wr_addr_d;
                            wb_len_q    <= sel_wr_len_d;
                            wb_happen_q <= 1'b1;
                            state_q     <= WR_BUSY;
                        end else begin
                            pf_addr_q   <= sel_rd_addr_d;
                            pf_len_q    <= sel_rd_len_d;
                            pf_happen_q <= 1'b1;
                            state_q     <= RD_BUSY;
                        end
                    end
                end
                RD_BUSY: begin
                    if (rd_fin) begin
                        pf_happen_q <= 1'b0;
                        rd_done_q   <= req_onehot(grant_q);
                        state_q     <= DRAIN;
`ifdef DMA_ARB_TIMEOUT_EN
                        if (!dma_page_fault_done) begin
                            timeout_q <= 1'b1;
                            sticky_q  <= 1'b1;
                        end
`endif
                    end
                end
                WR_BUSY: begin
                    if (wr_fin) begin
                        wb_happen_q <= 1'b0;
                        wr_done_q   <= req_onehot(grant_q);
                        state_q     <= DRAIN;
`ifdef DMA_ARB_TIMEOUT_EN
                        if (!dma_write_back_done) begin
                            timeout_q <= 1'b1;
                            sticky_q  <= 1'b1;
                        end
`endif
                    end
                end
                DRAIN: begin
                    if (!dma_page_fault_done && !dma_write_back_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_rd_done              = rd_done_q;
    assign req_wr_done              = wr_done_q;
    assign dma_page_fault_happen    = pf_happen_q;
    assign dma_page_fault_addr      = pf_addr_q;
    assign dma_page_fault_burst_len = pf_len_q;
    assign dma_write_back_happen    = wb_happen_q;
    assign dma_write_back_addr      = wb_addr_q;
    assign dma_write_back_burst_len = wb_len_q;
    assign grant_id                 = grant_q;
    assign busy                     = busy_q;

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Scoreboard bench for dma_request_arbiter: expected DMA commands are queued when requests are raised.
// Define DMA_ARB_TIMEOUT_EN to also exercise the timeout abort.
module tb_dma_request_arbiter;

    typedef struct packed {
        logic        is_wr;
        logic        id;
        logic [31:0] addr;
        logic [7:0]  len;
    } exp_t;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic [1:0]  req_rd, req_wr;
    logic [63:0] req_rd_addr, req_wr_addr;
    logic [15:0] req_rd_len, req_wr_len;
    logic [1:0]  req_rd_done, req_wr_done;
    logic        pf_happen, pf_done, wb_happen, wb_done;
    logic [31:0] pf_addr, wb_addr;
    logic [7:0]  pf_len, wb_len;
    logic        grant_id, busy;
`ifdef DMA_ARB_TIMEOUT_EN
    logic        arb_timeout, arb_timeout_sticky;
`endif

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   dbl_cnt = 0;

    dma_request_arbiter dut (
        .cpu_clk                  (cpu_clk),
        .cpu_rst_n                (cpu_rst_n),
        .req_rd                   (req_rd),
        .req_rd_addr              (req_rd_addr),
        .req_rd_len               (req_rd_len),
        .req_rd_done              (req_rd_done),
        .req_wr                   (req_wr),
        .req_wr_addr              (req_wr_addr),
        .req_wr_len               (req_wr_len),
        .req_wr_done              (req_wr_done),
        .dma_page_fault_happen    (pf_happen),
        .dma_page_fault_done      (pf_done),
        .dma_page_fault_addr      (pf_addr),
        .dma_page_fault_burst_len (pf_len),
        .dma_write_back_happen    (wb_happen),
        .dma_write_back_done      (wb_done),
        .dma_write_back_addr      (wb_addr),
        .dma_write_back_burst_len (wb_len),
        .grant_id                 (grant_id),
        .busy                     (busy)
`ifdef DMA_ARB_TIMEOUT_EN
        ,
        .arb_timeout              (arb_timeout),
        .arb_timeout_sticky       (arb_timeout_sticky)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(negedge cpu_clk) begin
        if (cpu_rst_n && pf_happen && wb_happen) dbl_cnt++;
    end

    function automatic exp_t obs_now();
        exp_t o;
        o.is_wr = wb_happen;
        o.id    = grant_id;
        o.addr  = wb_happen ? wb_addr : pf_addr;
        o.len   = wb_happen ? wb_len : pf_len;
        return o;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = 'x;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        return e;
    endfunction

    task automatic set_rd(input int id, input logic [31:0] a, input logic [7:0] l);
        req_rd_addr[id*32 +: 32] = a;
        req_rd_len[id*8 +: 8]    = l;
        req_rd[id]               = 1'b1;
        sb_q.push_back('{is_wr: 1'b0, id: 1'(id), addr: a, len: l});
    endtask

    task automatic set_wr(input int id, input logic [31:0] a, input logic [7:0] l);
        req_wr_addr[id*32 +: 32] = a;
        req_wr_len[id*8 +: 8]    = l;
        req_wr[id]               = 1'b1;
        sb_q.push_back('{is_wr: 1'b1, id: 1'(id), addr: a, len: l});
    endtask

    task automatic apply_reset();
        cpu_rst_n = 1'b0;
        req_rd = '0; req_wr = '0;
        req_rd_addr = '0; req_wr_addr = '0;
        req_rd_len = '0; req_wr_len = '0;
        pf_done = 1'b0; wb_done = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
    endtask

    task automatic wait_happen(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int k = 0; k < 64; k++) begin
            if (!ok) begin
                @(negedge cpu_clk);
                waited++;
                if (pf_happen || wb_happen) ok = 1'b1;
            end
        end
    endtask

    // Raises the DMA done level for `hold` cycles, then watches a few more cycles.
    task automatic run_done(input bit is_wr, input int hold, input bit drop,
                            output int n_pulse, output logic [3:0] mask,
                            output bit happen_after, output bit early);
        n_pulse = 0; mask = '0; early = 1'b0; happen_after = 1'b1;
        if (is_wr) wb_done = 1'b1; else pf_done = 1'b1;
        for (int k = 0; k < hold + 4; k++) begin
            if (k == hold) begin pf_done = 1'b0; wb_done = 1'b0; end
            @(negedge cpu_clk);
            if (k == 0) happen_after = pf_happen | wb_happen;
            if (k <= hold && (pf_happen || wb_happen)) early = 1'b1;
            n_pulse += int'($countones({req_wr_done, req_rd_done}));
            mask |= {req_wr_done, req_rd_done};
            if (drop) begin
                req_rd &= ~req_rd_done;
                req_wr &= ~req_wr_done;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({pf_happen, wb_happen, pf_addr, pf_len, wb_addr, wb_len, grant_id, busy,
             req_rd_done, req_wr_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pf=%b wb=%b busy=%b gid=%b pfa=%h wba=%h, required all zero",
                     pf_happen, wb_happen, busy, grant_id, pf_addr, wb_addr);
        end
        checks++;
        if (dut.u_rr.rr_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_rr: got %b required 0", dut.u_rr.rr_q);
        end
    endtask

    task automatic test_single_refill();
        bit ok, ha, early; int waited, np; logic [3:0] m; exp_t e, o;
        set_rd(0, 32'h1000, 8'd8);
        wait_happen(ok, waited);
        e = pop_exp(); o = obs_now();
        checks++;
        if (!ok || waited != 1) begin
            errors++;
            $display("FAIL single_latency: ok=%0b cycles=%0d required 1", ok, waited);
        end
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL single_txn: got %h required %h", o, e);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b required 1", busy);
        end
        run_done(1'b0, 3, 1'b1, np, m, ha, early);
        checks++;
        if (ha !== 1'b0) begin
            errors++;
            $display("FAIL single_happen_drop: got %b required 0", ha);
        end
        checks++;
        if (np != 1 || m !== 4'b0001) begin
            errors++;
            $display("FAIL single_done_pulse: count=%0d mask=%b required 1 and 0001", np, m);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_wrong_channel();
        bit ok, ha, early; int waited, np; logic [3:0] m; exp_t e, o; bit held; int stray;
        set_rd(1, 32'h7000, 8'h10);
        wait_happen(ok, waited);
        e = pop_exp(); o = obs_now();
        checks++;
        if (!ok || o !== e) begin
            errors++;
            $display("FAIL wrongch_txn: ok=%0b got %h required %h", ok, o, e);
        end
        wb_done = 1'b1;
        held = 1'b1; stray = 0;
        repeat (3) begin
            @(negedge cpu_clk);
            if (pf_happen !== 1'b1) held = 1'b0;
            stray += int'($countones({req_wr_done, req_rd_done}));
        end
        wb_done = 1'b0;
        checks++;
        if (!held || stray != 0) begin
            errors++;
            $display("FAIL wrongch_ignored: happen_held=%0b pulses=%0d required 1 and 0", held, stray);
        end
        run_done(1'b0, 1, 1'b1, np, m, ha, early);
        checks++;
        if (np != 1 || m !== 4'b0010) begin
            errors++;
            $display("FAIL wrongch_done: count=%0d mask=%b required 1 and 0010", np, m);
        end
    endtask

    task automatic test_wr_then_rd();
        bit ok, ha, early; int waited, np; logic [3:0] m; exp_t e, o;
        set_wr(1, 32'h2000, 8'd4);
        set_rd(1, 32'h3000, 8'd8);
        for (int t = 0; t < 2; t++) begin
            wait_happen(ok, waited);
            e = pop_exp(); o = obs_now();
            checks++;
            if (!ok || o !== e) begin
                errors++;
                $display("FAIL wr_rd_order[%0d]: ok=%0b got %h required %h", t, ok, o, e);
            end
            run_done(e.is_wr, 2, 1'b1, np, m, ha, early);
            checks++;
            if (np != 1 || m !== (e.is_wr ? 4'b1000 : 4'b0010)) begin
                errors++;
                $display("FAIL wr_rd_done[%0d]: count=%0d mask=%b", t, np, m);
            end
        end
    endtask

    task automatic test_contention();
        bit ok, ha, early; int waited, np; logic [3:0] m; exp_t e, o;
        apply_reset();
        set_rd(0, 32'hA000, 8'd1);
        set_rd(1, 32'hB000, 8'd2);
        sb_q.push_back('{is_wr: 1'b0, id: 1'b0, addr: 32'hA000, len: 8'd1});
        sb_q.push_back('{is_wr: 1'b0, id: 1'b1, addr: 32'hB000, len: 8'd2});
        for (int t = 0; t < 4; t++) begin
            wait_happen(ok, waited);
            e = pop_exp(); o = obs_now();
            checks++;
            if (!ok || o !== e) begin
                errors++;
                $display("FAIL contention_grant[%0d]: ok=%0b got %h required %h", t, ok, o, e);
            end
            run_done(1'b0, 1, 1'b0, np, m, ha, early);
            checks++;
            if (np != 1 || m !== (4'b0001 << e.id)) begin
                errors++;
                $display("FAIL contention_done[%0d]: count=%0d mask=%b", t, np, m);
            end
        end
        req_rd = '0;
        checks++;
        if (dbl_cnt != 0) begin
            errors++;
            $display("FAIL double_grant: got %0d cycles required 0", dbl_cnt);
        end
    endtask

    task automatic test_sticky_done();
        bit ok, ha, early; int waited, np; logic [3:0] m; exp_t e, o;
        apply_reset();
        set_wr(0, 32'h5000, 8'h20);
        wait_happen(ok, waited);
        e = pop_exp(); o = obs_now();
        checks++;
        if (!ok || o !== e) begin
            errors++;
            $display("FAIL sticky_first: ok=%0b got %h required %h", ok, o, e);
        end
        set_rd(1, 32'h4000, 8'h40);
        run_done(1'b1, 6, 1'b1, np, m, ha, early);
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL sticky_early_happen: got %b required 0", early);
        end
        checks++;
        if (np != 1 || m !== 4'b0100) begin
            errors++;
            $display("FAIL sticky_done_pulse: count=%0d mask=%b required 1 and 0100", np, m);
        end
        wait_happen(ok, waited);
        e = pop_exp(); o = obs_now();
        checks++;
        if (!ok || o !== e) begin
            errors++;
            $display("FAIL sticky_next: ok=%0b got %h required %h", ok, o, e);
        end
        run_done(1'b0, 1, 1'b1, np, m, ha, early);
        checks++;
        if (m !== 4'b0010) begin
            errors++;
            $display("FAIL sticky_next_done: mask=%b required 0010", m);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, ha, early; int waited, np, stray; logic [3:0] m; exp_t e, o;
        apply_reset();
        set_rd(0, 32'h6000, 8'd8);
        wait_happen(ok, waited);
        e = pop_exp(); o = obs_now();
        run_done(1'b0, 1, 1'b1, np, m, ha, early);
        set_rd(0, 32'h6100, 8'd9);
        wait_happen(ok, waited);
        e = pop_exp(); o = obs_now();
        checks++;
        if (!ok || o !== e || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_txn: ok=%0b busy=%b got %h required %h", ok, busy, o, e);
        end
        cpu_rst_n = 1'b0;
        #1;
        checks++;
        if ({pf_happen, busy, grant_id, dut.u_rr.rr_q, pf_addr} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: happen=%b busy=%b gid=%b rr=%b addr=%h required zero",
                     pf_happen, busy, grant_id, dut.u_rr.rr_q, pf_addr);
        end
        req_rd = '0;
        stray = 0;
        repeat (3) begin
            @(negedge cpu_clk);
            stray += int'($countones({req_wr_done, req_rd_done}));
        end
        cpu_rst_n = 1'b1;
        repeat (2) begin
            @(negedge cpu_clk);
            stray += int'($countones({req_wr_done, req_rd_done}));
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rstmid_no_done: pulses=%0d required 0", stray);
        end
    endtask

`ifdef DMA_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, ha, early, seen; int waited, np, n; logic [3:0] m, pm; exp_t e, o;
        apply_reset();
        set_rd(0, 32'h8000, 8'd3);
        wait_happen(ok, waited);
        e = pop_exp(); o = obs_now();
        checks++;
        if (!ok || o !== e) begin
            errors++;
            $display("FAIL timeout_first: ok=%0b got %h required %h", ok, o, e);
        end
        set_rd(1, 32'h9000, 8'd4);
        n = 0; seen = 1'b0; pm = '0;
        while (!seen && n < 70000) begin
            @(negedge cpu_clk);
            n++;
            if (arb_timeout) begin
                seen = 1'b1;
                pm = {req_wr_done, req_rd_done};
                req_rd &= ~req_rd_done;
            end
        end
        checks++;
        if (!seen || n != 65535) begin
            errors++;
            $display("FAIL timeout_cycles: seen=%0b cycles=%0d required 65535", seen, n);
        end
        checks++;
        if (pm !== 4'b0001 || arb_timeout_sticky !== 1'b1 || pf_happen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: mask=%b sticky=%b happen=%b", pm, arb_timeout_sticky, pf_happen);
        end
        wait_happen(ok, waited);
        e = pop_exp(); o = obs_now();
        checks++;
        if (!ok || o !== e) begin
            errors++;
            $display("FAIL timeout_next: ok=%0b got %h required %h", ok, o, e);
        end
        run_done(1'b0, 1, 1'b1, np, m, ha, early);
        checks++;
        if (m !== 4'b0010 || arb_timeout_sticky !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: mask=%b sticky=%b", m, arb_timeout_sticky);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_refill();
        test_wrong_channel();
        test_wr_then_rd();
        test_contention();
        test_sticky_done();
        test_reset_mid();
`ifdef DMA_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_request_arbiter.md
Name: dma_request_arbiter

Overview:
- Shares the single DMA engine between two cache requesters: requester 0 is the I-cache and requester 1 is the D-cache.
- Each requester can raise a page-fault refill (read) and a write-back (write).
- The block serialises these onto the DMA's page-fault and write-back happen/done handshakes, one transaction at a time.
- It sits in the cpu_clk domain, between the cache controllers and the dma block.

Parameters:
ADDR_WIDTH, 32, byte address width
READ_BURST_LEN, 8, width of read burst-length field
WRITE_BURST_LEN, 8, width of write burst-length field

Ports:
cpu_clk  input  1  block clock
cpu_rst_n  input  1  reset; asynchronous, active-low
req_rd  input  2  per-requester refill request (level)
req_rd_addr  input  2*ADDR_WIDTH  refill address; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_rd_len  input  2*READ_BURST_LEN  refill burst length, packed the same way
req_rd_done  output  2  one-cycle refill-complete pulse per requester
req_wr  input  2  per-requester write-back request (level)
req_wr_addr  input  2*ADDR_WIDTH  write-back address, packed
req_wr_len  input  2*WRITE_BURST_LEN  write-back burst length, packed
req_wr_done  output  2  one-cycle write-back-complete pulse per requester
dma_page_fault_happen  output  1  read command to DMA
dma_page_fault_done  input  1  DMA read complete (level)
dma_page_fault_addr  output  ADDR_WIDTH  latched read address
dma_page_fault_burst_len  output  READ_BURST_LEN  latched read length
dma_write_back_happen  output  1  write command to DMA
dma_write_back_done  input  1  DMA write complete (level)
dma_write_back_addr  output  ADDR_WIDTH  latched write address
dma_write_back_burst_len  output  WRITE_BURST_LEN  latched write length
grant_id  output  1  requester owning the DMA (valid while busy)
busy  output  1  transaction in flight

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer rr=0.
- States: IDLE, RD_BUSY, WR_BUSY, DRAIN.
- IDLE selection:
  - Start at requester rr, then try the other requester.
  - The first requester with any request pending wins.
  - Within the winner, write-back has priority over refill, so a dirty eviction precedes its refill.
- Grant timing: on a grant at edge t, at t+1:
  - addr/len are latched into the dma_* outputs;
  - the matching happen is asserted;
  - grant_id and busy are set.
- Grant latency: 1 cycle from request sampled to happen asserted.
- RD_BUSY / WR_BUSY:
  - Hold happen, addr and len stable.
  - Ignore all new requests.
  - When the matching done is sampled high at edge t, at t+1: happen=0, req_*_done[grant_id] pulses for exactly one cycle, rr <= ~grant_id, state goes to DRAIN.
- DRAIN: wait until both dma_*_done are sampled low, then go to IDLE and busy=0. This prevents a stale level-done from completing the next transaction.
- Done on the wrong channel (e.g. dma_write_back_done while in RD_BUSY) is ignored.
- Requester protocol:
  - A requester holds req and its addr/len until its done pulse, then drops req within 1 cycle.
  - A req still high in the cycle after its done pulse is treated as a new request.
- Simultaneous requests from both requesters in IDLE resolve by rr. Under continuous load, requesters alternate per transaction.
- Back-to-back: the minimum gap between done sampled and the next happen is 2 cycles (DRAIN plus IDLE select).
- Reset mid-transaction: all outputs are cleared asynchronously. No requester done pulse is emitted; requesters must also be reset.

Optional Feature:
DMA_ARB_TIMEOUT_EN
- With the macro: a 16-bit counter runs in RD_BUSY/WR_BUSY. At 65535 cycles without done, the block does the following:
  - aborts the transaction: happen=0, state DRAIN;
  - pulses the requester's done;
  - pulses a 1-cycle output arb_timeout, and sets sticky arb_timeout_sticky, which is cleared only by reset.
  - Both ports exist only under the macro.
- Without the macro: the block waits indefinitely and there is no counter.

Decomposition:
- Shared package dma_arb_pkg:
  - state enum (IDLE, RD_BUSY, WR_BUSY, DRAIN);
  - requester IDs REQ_ICACHE=0, REQ_DCACHE=1;
  - timeout constant ARB_TIMEOUT_CYCLES=65535.
- One natural sub-module: rr_arbiter2, a combinational 2-way round-robin pick plus registered pointer update.

Test Plan:
- Single refill: req_rd[0]=1, addr 0x1000, len 8. Expect page_fault_happen 1 cycle later with addr 0x1000 and len 8. DMA done is held 3 cycles. Expect one req_rd_done[0] pulse; happen low at done+1.
- Same requester wr+rd: requester 1 raises req_wr (0x2000) and req_rd (0x3000) together. Expect write_back first, then page_fault for 0x3000.
- Contention: both requesters hold req_rd continuously with rr=0. Expect grant sequence 0,1,0,1 and no double-grant.
- Sticky done: DMA holds done high 5 cycles after completion while a new request is pending. Expect no new happen until done is low, and exactly one done pulse.
- Reset mid-transfer: assert cpu_rst_n=0 during RD_BUSY. Expect happen=0, busy=0, rr=0 immediately, and no done pulse.
- Timeout (macro on): never assert DMA done. Expect arb_timeout at 65535 cycles, a requester done pulse, and the arbiter serving the next request.
